// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single shared memory bus.
// One access is in flight at a time. A wait counter bounds how long the slave may stall.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_valid_i,
    output logic                  imem_ready_o,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]            imem_we_i,
    output logic [WORD_WIDTH-1:0] imem_rdata_o,
    input  logic                  dmem_valid_i,
    output logic                  dmem_ready_o,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]            dmem_we_i,
    output logic [WORD_WIDTH-1:0] dmem_rdata_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_we_o,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic                  timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    grant_dmem_q;
    logic                    last_grant_dmem_q;
    logic                    grant_dmem_d;
    logic [CW-1:0]           wait_q;
    logic                    mem_valid_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [WORD_WIDTH-1:0]   mem_wdata_q;
    logic [3:0]              mem_we_q;
    logic                    imem_ready_q;
    logic                    dmem_ready_q;
    logic [WORD_WIDTH-1:0]   imem_rdata_q;
    logic [WORD_WIDTH-1:0]   dmem_rdata_q;
    logic                    timeout_q;

    // Arbitration: a lone requester wins; on conflict the port not granted last wins.
    always_comb begin
        grant_dmem_d = 1'b0;
        if (imem_valid_i && dmem_valid_i) begin
            grant_dmem_d = ~last_grant_dmem_q;
        end else if (dmem_valid_i) begin
            grant_dmem_d = 1'b1;
        end else begin
            grant_dmem_d = 1'b0;
        end
    end

    // Control FSM with all bus and port outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            grant_dmem_q      <= 1'b0;
            last_grant_dmem_q <= 1'b0;
            wait_q            <= '0;
            mem_valid_q       <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_we_q          <= 4'b0000;
            imem_ready_q      <= 1'b0;
            dmem_ready_q      <= 1'b0;
            imem_rdata_q      <= '0;
            dmem_rdata_q      <= '0;
            timeout_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    imem_ready_q <= 1'b0;
                    dmem_ready_q <= 1'b0;
                    if (imem_valid_i || dmem_valid_i) begin
                        state_q           <= BUSY;
                        grant_dmem_q      <= grant_dmem_d;
                        last_grant_dmem_q <= grant_dmem_d;
                        wait_q            <= '0;
                        mem_valid_q       <= 1'b1;
                        mem_addr_q        <= grant_dmem_d ? dmem_addr_i  : imem_addr_i;
                        mem_wdata_q       <= grant_dmem_d ? dmem_wdata_i : imem_wdata_i;
                        mem_we_q          <= grant_dmem_d ? dmem_we_i    : imem_we_i;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        state_q     <= RESP;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 4'b0000;
                        if (grant_dmem_q) begin
                            dmem_rdata_q <= mem_rdata_i;
                            dmem_ready_q <= 1'b1;
                        end else begin
                            imem_rdata_q <= mem_rdata_i;
                            imem_ready_q <= 1'b1;
                        end
                    end else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on the slave: complete the port with zero data.
                        state_q     <= RESP;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 4'b0000;
                        timeout_q   <= 1'b1;
                        wait_q      <= wait_q + CW'(1);
                        if (grant_dmem_q) begin
                            dmem_rdata_q <= '0;
                            dmem_ready_q <= 1'b1;
                        end else begin
                            imem_rdata_q <= '0;
                            imem_ready_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    imem_ready_q <= 1'b0;
                    dmem_ready_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    mem_valid_q  <= 1'b0;
                    mem_we_q     <= 4'b0000;
                    imem_ready_q <= 1'b0;
                    dmem_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_valid_o  = mem_valid_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q;
    assign imem_ready_o = imem_ready_q;
    assign dmem_ready_o = dmem_ready_q;
    assign imem_rdata_o = imem_rdata_q;
    assign dmem_rdata_o = dmem_rdata_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus transactions are queued when requests
// are driven and checked as the bus request rises and as the port completion pulses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid_i = 1'b0;
    logic        imem_ready_o;
    logic [31:0] imem_addr_i = 32'h0;
    logic [31:0] imem_wdata_i = 32'h0;
    logic [3:0]  imem_we_i = 4'h0;
    logic [31:0] imem_rdata_o;
    logic        dmem_valid_i = 1'b0;
    logic        dmem_ready_o;
    logic [31:0] dmem_addr_i = 32'h0;
    logic [31:0] dmem_wdata_i = 32'h0;
    logic [3:0]  dmem_we_i = 4'h0;
    logic [31:0] dmem_rdata_o;
    logic        mem_valid_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_we_o;
    logic        timeout_o;

    // Slave model and direct bus pokes
    logic        slave_rdy = 1'b0;
    logic [31:0] slave_rd = 32'h0;
    int          slave_cnt = 0;
    int          slave_wait = 0;
    logic        slave_fixed = 1'b0;
    logic [31:0] slave_fixed_data = 32'h0;
    logic        tb_rdy = 1'b0;
    logic [31:0] tb_rdata = 32'h0;

    wire         mem_ready_i = slave_rdy | tb_rdy;
    wire [31:0]  mem_rdata_i = slave_rdy ? slave_rd : tb_rdata;

    int tests_run = 0;
    int failed = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   cur_valid = 1'b0;
    bit   prev_mv = 1'b0;

    mem_arbiter #(
        .ADDR_WIDTH(32),
        .WORD_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o), .imem_addr_i(imem_addr_i),
        .imem_wdata_i(imem_wdata_i), .imem_we_i(imem_we_i), .imem_rdata_o(imem_rdata_o),
        .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o), .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return slave_fixed ? slave_fixed_data : (a ^ 32'hA5A5_0000);
    endfunction

    // Slave: answers slave_wait cycles after the bus request is first seen.
    always @(negedge clk) begin
        if (mem_valid_o && !rst) begin
            slave_rdy = (slave_cnt == slave_wait);
            slave_rd  = slave_data(mem_addr_o);
            slave_cnt = slave_cnt + 1;
        end else begin
            slave_rdy = 1'b0;
            slave_cnt = 0;
        end
    end

    // Scoreboard monitor: bus fields at each request rise, port/rdata at each completion.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_valid = 1'b0;
            prev_mv   = 1'b0;
        end else begin
            if (mem_valid_o && !prev_mv) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL bus_grant: unexpected request addr=%h, required no request", mem_addr_o);
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    if (mem_addr_o !== cur.addr || mem_wdata_o !== cur.wdata || mem_we_o !== cur.we) begin
                        failed++;
                        $display("FAIL bus_fields: got addr=%h wdata=%h we=%h, required addr=%h wdata=%h we=%h",
                                 mem_addr_o, mem_wdata_o, mem_we_o, cur.addr, cur.wdata, cur.we);
                    end
                end
            end
            if (imem_ready_o || dmem_ready_o) begin
                tests_run++;
                if (!cur_valid) begin
                    failed++;
                    $display("FAIL completion: unexpected ready imem=%b dmem=%b", imem_ready_o, dmem_ready_o);
                end else if (imem_ready_o === cur.is_d || dmem_ready_o !== cur.is_d || mem_we_o !== 4'b0000 ||
                             (cur.is_d ? dmem_rdata_o : imem_rdata_o) !== cur.rdata) begin
                    failed++;
                    $display("FAIL completion: got ready i/d=%b%b rdata i=%h d=%h we=%h, required dmem=%b rdata=%h we=0",
                             imem_ready_o, dmem_ready_o, imem_rdata_o, dmem_rdata_o, mem_we_o, cur.is_d, cur.rdata);
                end
                cur_valid = 1'b0;
            end
            prev_mv = mem_valid_o;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        imem_valid_i = 1'b0;
        dmem_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_valid_o, imem_ready_o, dmem_ready_o, mem_we_o, timeout_o} !== 8'b0) begin
            failed++;
            $display("FAIL reset_ctrl: got valid=%b rdy=%b%b we=%h to=%b, required all 0",
                     mem_valid_o, imem_ready_o, dmem_ready_o, mem_we_o, timeout_o);
        end
        tests_run++;
        if (imem_rdata_o !== 32'h0 || dmem_rdata_o !== 32'h0) begin
            failed++;
            $display("FAIL reset_rdata: got %h %h, required 0 0", imem_rdata_o, dmem_rdata_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_conflict();
        bit got_d = 1'b0;
        bit got_i = 1'b0;
        slave_wait = 0;
        exp_q.push_back('{1'b1, 32'h2000, 32'hCAFE_F00D, 4'b1111, 32'h2000 ^ 32'hA5A5_0000});
        exp_q.push_back('{1'b0, 32'h300, 32'h0, 4'b0000, 32'h300 ^ 32'hA5A5_0000});
        @(negedge clk);
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h2000; dmem_we_i = 4'b1111; dmem_wdata_i = 32'hCAFE_F00D;
        imem_valid_i = 1'b1; imem_addr_i = 32'h300;  imem_we_i = 4'b0000; imem_wdata_i = 32'h0;
        for (int c = 0; c < 40 && !got_i; c++) begin
            @(negedge clk);
            if (dmem_ready_o) begin
                dmem_valid_i = 1'b0;
                got_d = 1'b1;
            end
            if (imem_ready_o) begin
                tests_run++;
                if (!got_d) begin
                    failed++;
                    $display("FAIL conflict_order: got imem first, required dmem first");
                end
                imem_valid_i = 1'b0;
                got_i = 1'b1;
            end
        end
        if (!got_i) begin
            tests_run++;
            failed++;
            $display("FAIL conflict_done: got no imem completion, required one within 40 cycles");
        end
        dmem_valid_i = 1'b0;
        imem_valid_i = 1'b0;
    endtask

    task automatic test_imem_read();
        int n = 0;
        slave_wait = 2;
        slave_fixed = 1'b1;
        slave_fixed_data = 32'h0000_0013;
        exp_q.push_back('{1'b0, 32'h100, 32'h0, 4'b0000, 32'h0000_0013});
        @(negedge clk);
        imem_valid_i = 1'b1; imem_addr_i = 32'h100; imem_we_i = 4'b0000; imem_wdata_i = 32'h0;
        @(negedge clk);
        imem_valid_i = 1'b0;
        tests_run++;
        if (mem_valid_o !== 1'b1) begin
            failed++;
            $display("FAIL read_latency: got mem_valid_o=%b one cycle after request, required 1", mem_valid_o);
        end
        while (!imem_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 3 || imem_rdata_o !== 32'h0000_0013) begin
            failed++;
            $display("FAIL read_done: got %0d cycles rdata=%h, required 3 cycles rdata=00000013", n, imem_rdata_o);
        end
        @(negedge clk);
        tests_run++;
        if (imem_ready_o !== 1'b0 || imem_rdata_o !== 32'h0000_0013 || dmem_rdata_o !== (32'h2000 ^ 32'hA5A5_0000)) begin
            failed++;
            $display("FAIL read_hold: got rdy=%b irdata=%h drdata=%h, required 0 00000013 %h",
                     imem_ready_o, imem_rdata_o, dmem_rdata_o, 32'h2000 ^ 32'hA5A5_0000);
        end
        slave_fixed = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  cyc = 0;
        int  last_rise = -1;
        int  pulses = 0;
        bit  pv = 1'b0;
        bit  pr = 1'b0;
        slave_wait = 0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{1'b1, 32'h500, 32'h1234_5678, 4'b0011, 32'h500 ^ 32'hA5A5_0000});
            exp_q.push_back('{1'b0, 32'h400, 32'h0, 4'b0000, 32'h400 ^ 32'hA5A5_0000});
        end
        @(negedge clk);
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h500; dmem_we_i = 4'b0011; dmem_wdata_i = 32'h1234_5678;
        imem_valid_i = 1'b1; imem_addr_i = 32'h400; imem_we_i = 4'b0000; imem_wdata_i = 32'h0;
        while (pulses < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_valid_o && !pv) begin
                if (last_rise >= 0) begin
                    tests_run++;
                    if (cyc - last_rise != 3) begin
                        failed++;
                        $display("FAIL b2b_spacing: got %0d cycles between requests, required 3", cyc - last_rise);
                    end
                end
                last_rise = cyc;
            end
            pv = mem_valid_o;
            if (imem_ready_o || dmem_ready_o) begin
                tests_run++;
                if (pr) begin
                    failed++;
                    $display("FAIL b2b_pulse: got ready high 2 cycles, required 1");
                end
                pulses++;
                if (pulses == 4) begin
                    dmem_valid_i = 1'b0;
                    imem_valid_i = 1'b0;
                end
            end
            pr = imem_ready_o || dmem_ready_o;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (pulses != 4 || mem_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL b2b_done: got %0d pulses valid=%b, required 4 pulses valid=0", pulses, mem_valid_o);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        slave_wait = 1000;
        exp_q.push_back('{1'b0, 32'h600, 32'h0, 4'b0000, 32'h0});
        @(negedge clk);
        imem_valid_i = 1'b1; imem_addr_i = 32'h600; imem_we_i = 4'b0000;
        @(negedge clk);
        imem_valid_i = 1'b0;
        while (mem_valid_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 4 || imem_ready_o !== 1'b1 || imem_rdata_o !== 32'h0 || timeout_o !== 1'b1) begin
            failed++;
            $display("FAIL timeout_hit: got busy=%0d rdy=%b rdata=%h to=%b, required 4 1 00000000 1",
                     n, imem_ready_o, imem_rdata_o, timeout_o);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (timeout_o !== 1'b1 || imem_ready_o !== 1'b0) begin
            failed++;
            $display("FAIL timeout_sticky: got to=%b rdy=%b, required 1 0", timeout_o, imem_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int n = 0;
        slave_wait = 1000;
        exp_q.push_back('{1'b1, 32'h700, 32'h0BAD_F00D, 4'b1111, 32'h0});
        @(negedge clk);
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h700; dmem_we_i = 4'b1111; dmem_wdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        dmem_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_valid_o, imem_ready_o, dmem_ready_o, mem_we_o, timeout_o} !== 8'b0 ||
            imem_rdata_o !== 32'h0 || dmem_rdata_o !== 32'h0) begin
            failed++;
            $display("FAIL midrst_state: got valid=%b rdy=%b%b we=%h to=%b rdata=%h/%h, required all 0",
                     mem_valid_o, imem_ready_o, dmem_ready_o, mem_we_o, timeout_o, imem_rdata_o, dmem_rdata_o);
        end
        rst = 1'b0;
        tb_rdy = 1'b1;
        tb_rdata = 32'h1111_1111;
        @(negedge clk);
        tb_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (imem_ready_o || dmem_ready_o || mem_valid_o) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            failed++;
            $display("FAIL midrst_quiet: got activity after abandoned access, required none");
        end
        slave_wait = 1;
        exp_q.push_back('{1'b0, 32'h800, 32'h0, 4'b0000, 32'h800 ^ 32'hA5A5_0000});
        imem_valid_i = 1'b1; imem_addr_i = 32'h800; imem_we_i = 4'b0000;
        @(negedge clk);
        imem_valid_i = 1'b0;
        while (!imem_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!imem_ready_o) begin
            failed++;
            $display("FAIL midrst_next: got no completion after reset, required one within 20 cycles");
        end
    endtask

    task automatic test_stray_ready();
        bit bad = 1'b0;
        repeat (2) @(negedge clk);
        tb_rdy = 1'b1;
        tb_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (imem_ready_o || dmem_ready_o || mem_valid_o ||
                imem_rdata_o !== (32'h800 ^ 32'hA5A5_0000) || dmem_rdata_o !== 32'h0) bad = 1'b1;
        end
        tb_rdy = 1'b0;
        tests_run++;
        if (bad) begin
            failed++;
            $display("FAIL stray_ready: got rdy=%b%b rdata=%h/%h, required 00 %h/00000000",
                     imem_ready_o, dmem_ready_o, imem_rdata_o, dmem_rdata_o, 32'h800 ^ 32'hA5A5_0000);
        end
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_imem_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_stray_ready();
        repeat (2) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0 || cur_valid) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d queued, in-flight=%b, required 0 0", exp_q.size(), cur_valid);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
